// File: rtl/jet_logit_argmax_if.sv
// jet_logit_argmax_if: logit-vector request and argmax-result handshake bundle
interface jet_logit_argmax_if #(
    parameter int N_CLASS = 5,
    parameter int W       = 12,
    parameter int IDX_W   = (N_CLASS > 1) ? $clog2(N_CLASS) : 1
);
    logic                 in_valid;
    logic                 in_ready;
    logic [N_CLASS*W-1:0] in_logits;
    logic                 out_valid;
    logic                 out_ready;
    logic [IDX_W-1:0]     out_class;
    logic [W-1:0]         out_max;
    logic [W:0]           out_margin;
    modport master (
        output in_valid, in_logits, out_ready,
        input  in_ready, out_valid, out_class, out_max, out_margin
    );
    modport slave (
        input  in_valid, in_logits, out_ready,
        output in_ready, out_valid, out_class, out_max, out_margin
    );
endinterface

// File: rtl/jet_logit_argmax.sv
// jet_logit_argmax: serial argmax over dense_4 logits, one logit per cycle.
// Define ARGMAX_MARGIN_EN to track the runner-up and report top-1 minus top-2.
module jet_logit_argmax #(
    parameter int N_CLASS = 5,
    parameter int W       = 12,
    parameter int NFRAC   = 6,
    parameter int IDX_W   = (N_CLASS > 1) ? $clog2(N_CLASS) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    jet_logit_argmax_if.slave  bus
);
    localparam int CNT_W = $clog2(N_CLASS + 1);
    if (N_CLASS < 1 || NFRAC < 0 || NFRAC >= W) begin : g_bad_cfg
        $error("jet_logit_argmax: invalid N_CLASS/NFRAC");
    end
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
    state_t               state, state_nxt;
    logic [N_CLASS*W-1:0] lat;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     best_idx, res_class;
    logic signed [W-1:0]  best, cur;
    logic [W-1:0]         res_max;
    logic [W:0]           margin;
    logic                 last;
    // Remaining logits are shifted down so the candidate is always the low W bits.
    assign cur  = lat[W-1:0];
    assign last = cnt == CNT_W'(N_CLASS);
    assign bus.in_ready  = state == IDLE;
    assign bus.out_valid = state == DONE;
    assign bus.out_class = res_class;
    assign bus.out_max   = res_max;
`ifdef ARGMAX_MARGIN_EN
    logic signed [W-1:0] second;
    logic [W:0]          res_margin;
    // A single class has no runner-up, so its margin is defined as zero.
    assign margin = (N_CLASS == 1) ? '0 : {best[W-1], best} - {second[W-1], second};
    assign bus.out_margin = res_margin;
    // Runner-up tracker: displaced leader or any value at/above the current runner-up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            second     <= {1'b1, {(W-1){1'b0}}};
            res_margin <= '0;
        end else if (state == IDLE && bus.in_valid) begin
            second <= {1'b1, {(W-1){1'b0}}};
        end else if (state == SCAN && last) begin
            res_margin <= margin;
        end else if (state == SCAN) begin
            second <= (cur > best) ? best : (cur >= second) ? cur : second;
        end
    end
`else
    assign margin = '0;
    assign bus.out_margin = margin;
`endif
    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end
    // Next state: accept in IDLE, leave SCAN once every logit is folded in, hold DONE until taken.
    always_comb begin
        state_nxt = state;
        if (state == IDLE && bus.in_valid)      state_nxt = SCAN;
        else if (state == SCAN && last)         state_nxt = DONE;
        else if (state == DONE && bus.out_ready) state_nxt = IDLE;
    end
    // Scan datapath: strict greater-than keeps the lower index on ties.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat       <= '0;
            cnt       <= '0;
            best_idx  <= '0;
            best      <= '0;
            res_class <= '0;
            res_max   <= '0;
        end else if (state == IDLE && bus.in_valid) begin
            lat      <= bus.in_logits >> W;
            best     <= bus.in_logits[W-1:0];
            best_idx <= '0;
            cnt      <= CNT_W'(1);
        end else if (state == SCAN && last) begin
            res_class <= best_idx;
            res_max   <= best;
        end else if (state == SCAN) begin
            if (cur > best) begin
                best     <= cur;
                best_idx <= IDX_W'(cnt);
            end
            lat <= lat >> W;
            cnt <= cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_jet_logit_argmax.sv
// tb_jet_logit_argmax: directed-vector bench for the serial logit argmax
module tb_jet_logit_argmax;
`ifdef ARGMAX_MARGIN_EN
    localparam bit MEN = 1'b1;
`else
    localparam bit MEN = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    jet_logit_argmax_if #(.N_CLASS(5), .W(12), .IDX_W(3)) bus ();
    jet_logit_argmax #(.N_CLASS(5), .W(12), .NFRAC(6), .IDX_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );
    always #5 clk = ~clk;
    function automatic logic [59:0] pack(input int a0, input int a1, input int a2, input int a3, input int a4);
        logic [59:0] v;
        v = {a4[11:0], a3[11:0], a2[11:0], a1[11:0], a0[11:0]};
        return v;
    endfunction
    task automatic send(input string name, input logic [59:0] lg);
        int t;
        t = 0;
        while (bus.in_ready !== 1'b1 && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL %s accept_wait: in_ready=%b required 1", name, bus.in_ready);
        end
        bus.in_valid  = 1'b1;
        bus.in_logits = lg;
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        bus.in_logits = ~lg;
    endtask
    task automatic run_vec(input string name, input logic [59:0] lg, input int ecls, input int emax, input int emar);
        logic [2:0]  xcls;
        logic [11:0] xmax;
        logic [12:0] xmar;
        xcls = 3'(ecls);
        xmax = 12'(emax);
        xmar = MEN ? 13'(emar) : 13'd0;
        send(name, lg);
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (bus.out_valid !== (k == 5)) begin
                n_err++;
                $display("FAIL %s latency edge %0d: out_valid=%b required %b", name, k, bus.out_valid, k == 5);
            end
        end
        n_cmp++;
        if (bus.out_class !== xcls) begin
            n_err++;
            $display("FAIL %s out_class: got %0d required %0d", name, bus.out_class, xcls);
        end
        n_cmp++;
        if (bus.out_max !== xmax) begin
            n_err++;
            $display("FAIL %s out_max: got %h required %h", name, bus.out_max, xmax);
        end
        n_cmp++;
        if (bus.out_margin !== xmar) begin
            n_err++;
            $display("FAIL %s out_margin: got %0d required %0d", name, bus.out_margin, xmar);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL %s release: out_valid=%b in_ready=%b required 0/1", name, bus.out_valid, bus.in_ready);
        end
    endtask
    task automatic test_reset;
        #2;
        n_cmp++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset handshake: in_ready=%b out_valid=%b required 1/0", bus.in_ready, bus.out_valid);
        end
        n_cmp++;
        if (bus.out_class !== 3'd0 || bus.out_max !== 12'd0 || bus.out_margin !== 13'd0) begin
            n_err++;
            $display("FAIL reset outputs: class=%0d max=%h margin=%h required 0/000/0000", bus.out_class, bus.out_max, bus.out_margin);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask
    task automatic test_vectors;
        run_vec("mixed", pack(-4, -5, -5, 5, 13), 4, 13, 8);
        run_vec("all_tie", pack(64, 64, 64, 64, 64), 0, 64, 0);
        run_vec("all_neg", pack(-64, -1, -128, -2, -300), 1, -1, 1);
        run_vec("extremes", pack(2047, -2048, 0, 0, 0), 0, 2047, 2047);
    endtask
    task automatic test_backpressure;
        send("bp", pack(-4, -5, -5, 5, 13));
        repeat (5) begin
            @(posedge clk); #1;
        end
        for (int i = 0; i < 10; i++) begin
            bus.in_valid  = 1'b1;
            bus.in_logits = pack(100, 0, 0, 0, 0);
            n_cmp++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_class !== 3'd4 || bus.out_max !== 12'd13) begin
                n_err++;
                $display("FAIL bp hold cycle %0d: valid=%b ready=%b class=%0d max=%h required 1/0/4/00d",
                         i, bus.out_valid, bus.in_ready, bus.out_class, bus.out_max);
            end
            @(posedge clk); #1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        n_cmp++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_class !== 3'd4) begin
            n_err++;
            $display("FAIL bp release: in_ready=%b out_valid=%b class=%0d required 1/0/4", bus.in_ready, bus.out_valid, bus.out_class);
        end
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (bus.out_valid !== 1'b0 || bus.out_class !== 3'd4) begin
                n_err++;
                $display("FAIL bp ignored_input cycle %0d: out_valid=%b class=%0d required 0/4", i, bus.out_valid, bus.out_class);
            end
        end
    endtask
    task automatic test_reset_mid_scan;
        send("rst_scan", pack(1, 2, 3, 4, 5));
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_class !== 3'd0 || bus.out_max !== 12'd0) begin
            n_err++;
            $display("FAIL rst_scan async: in_ready=%b out_valid=%b class=%0d max=%h required 1/0/0/000",
                     bus.in_ready, bus.out_valid, bus.out_class, bus.out_max);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
                n_err++;
                $display("FAIL rst_scan quiet cycle %0d: out_valid=%b in_ready=%b required 0/1", i, bus.out_valid, bus.in_ready);
            end
        end
        run_vec("after_rst", pack(0, 0, 0, 9, 0), 3, 9, 9);
    endtask
    initial begin
        bus.in_valid  = 1'b0;
        bus.in_logits = '0;
        bus.out_ready = 1'b0;
        test_reset;
        test_vectors;
        test_backpressure;
        test_reset_mid_scan;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
